// File: rtl/ram_req_ctrl.sv
// rtl/ram_req_ctrl.sv - request front-end for the RAM: issues RAM strobes, returns reads through a 2-entry FIFO, runs a fill sweep
module ram_req_ctrl #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  init_start,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   fill_cnt;
  logic                    rd_inflight;
  logic [DATA_WIDTH-1:0]   fifo_mem [2];
  logic                    fifo_wr_ptr;
  logic                    fifo_rd_ptr;
  logic [1:0]              fifo_count;
  logic [1:0]              occupancy;
  logic                    req_hs;
  logic                    rsp_pop;

  // A read in flight reserves its FIFO slot, so the FIFO can never overflow.
  assign occupancy = fifo_count + {1'b0, rd_inflight};
  assign req_ready = !rst && (state == IDLE) && !init_start && (occupancy < 2'd2);
  assign req_hs    = req_valid && req_ready;
  assign rsp_valid = !rst && (fifo_count != 2'd0);
  assign rsp_rdata = fifo_mem[fifo_rd_ptr];
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign busy      = !rst && (state == FILL);

  always_comb begin
    ram_cs    = 1'b0;
    ram_wen   = 1'b0;
    ram_ren   = 1'b0;
    ram_waddr = '0;
    ram_raddr = '0;
    ram_wdata = '0;
    if (!rst) begin
      if (state == FILL) begin
        ram_cs    = 1'b1;
        ram_wen   = 1'b1;
        ram_waddr = fill_cnt;
        ram_wdata = INIT_VAL;
      end else if (req_hs) begin
        ram_cs = 1'b1;
        if (req_we) begin
          ram_wen   = 1'b1;
          ram_waddr = req_addr;
          ram_wdata = req_wdata;
        end else begin
          ram_ren   = 1'b1;
          ram_raddr = req_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fill_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_start) begin
            state    <= FILL;
            fill_cnt <= '0;
          end
        end
        FILL: begin
          if (fill_cnt == LAST_ADDR) begin
            state    <= IDLE;
            fill_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM read data is registered, so it is captured one edge after the read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_inflight <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      rd_inflight <= req_hs && !req_we;
      if (rd_inflight) begin
        fifo_mem[fifo_wr_ptr] <= ram_rdata;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (rsp_pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      case ({rd_inflight, rsp_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb/tb_ram_req_ctrl.sv - bench for ram_req_ctrl with a behavioural RAM and a memory/response-queue reference model
module tb_ram_req_ctrl;
  localparam int         AW    = 4;
  localparam int         DW    = 8;
  localparam int         DEPTH = 16;
  localparam logic [7:0] INIT  = 8'h00;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_start, busy;
  logic          ram_cs, ram_wen, ram_ren;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];

  logic [1:0] rdy_mode;
  bit         rnd_bit;

  always #5 clk = ~clk;

  ram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_start(init_start), .busy(busy),
    .ram_cs(ram_cs), .ram_wen(ram_wen), .ram_ren(ram_ren),
    .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Behavioural RAM: registered read data, valid one cycle after ren.
  logic [DW-1:0] ram_mem [2**AW];
  logic [DW-1:0] ram_q;
  assign ram_rdata = ram_q;
  always @(posedge clk) begin
    if (ram_cs && ram_wen) ram_mem[ram_waddr] <= ram_wdata;
    if (ram_cs && ram_ren) ram_q <= ram_mem[ram_raddr];
  end

  assign rsp_ready = (rdy_mode == 2'd2) ? rnd_bit : rdy_mode[0];
  always @(posedge clk) begin
    #2;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) got_q.push_back(rsp_rdata);
  end

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (1) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        errors++; checks++;
        $display("FAIL send_timeout addr %0d req_ready %b required 1", a, req_ready);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "request never accepted");
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic commit();
    @(posedge clk);
    if (req_we) model_mem[req_addr] = req_wdata;
    else        exp_q.push_back(model_mem[req_addr]);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    send(we, a, d);
    commit();
  endtask

  task automatic model_fill(input int upto);
    for (int a = 0; a < upto; a++) model_mem[a] = INIT;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((got_q.size() < exp_q.size() || rsp_valid === 1'b1) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d responses required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'h33;
    init_start = 1'b0; rdy_mode = 2'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy, ram_cs, ram_wen, ram_ren} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl ready/valid/busy/cs/wen/ren %b required 000000",
               {req_ready, rsp_valid, busy, ram_cs, ram_wen, ram_ren});
    end
    checks++;
    if ({ram_waddr, ram_raddr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus waddr %0d raddr %0d wdata %h required 0", ram_waddr, ram_raddr, ram_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset ready %b busy %b rsp_valid %b required 1 0 0", req_ready, busy, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    rdy_mode = 2'd1;
    send(1'b1, 4'd3, 8'hA5);
    checks++;
    if ({ram_cs, ram_wen, ram_ren} !== 3'b110 || ram_waddr !== 4'd3 || ram_wdata !== 8'hA5 || ram_raddr !== 4'd0) begin
      errors++;
      $display("FAIL write_strobes cs/wen/ren %b waddr %0d wdata %h raddr %0d required 110 3 a5 0",
               {ram_cs, ram_wen, ram_ren}, ram_waddr, ram_wdata, ram_raddr);
    end
    commit();
    send(1'b0, 4'd3, 8'($urandom));
    checks++;
    if ({ram_cs, ram_wen, ram_ren} !== 3'b101 || ram_raddr !== 4'd3 || ram_waddr !== 4'd0 || ram_wdata !== 8'h00) begin
      errors++;
      $display("FAIL read_strobes cs/wen/ren %b raddr %0d waddr %0d wdata %h required 101 3 0 00",
               {ram_cs, ram_wen, ram_ren}, ram_raddr, ram_waddr, ram_wdata);
    end
    commit();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || ram_cs !== 1'b0) begin
      errors++;
      $display("FAIL read_latency_early rsp_valid %b ram_cs %b required 0 0", rsp_valid, ram_cs);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL read_latency rsp_valid %b rdata %h required 1 a5", rsp_valid, rsp_rdata);
    end
    @(posedge clk); #1;
    wait_drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wr_rd_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wr_rd_data[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    rdy_mode = 2'd1;
    for (int a = 1; a <= 3; a++) xfer(1'b1, 4'(a), 8'($urandom));
    rdy_mode = 2'd0;
    xfer(1'b0, 4'd1, 8'h00);
    xfer(1'b0, 4'd2, 8'h00);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== exp_q[0]) begin
        errors++;
        $display("FAIL bp_hold[%0d] ready %b valid %b rdata %h required 0 1 %h",
                 i, req_ready, rsp_valid, rsp_rdata, exp_q[0]);
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL bp_no_pop got %0d responses required 0", got_q.size());
    end
    @(posedge clk); #1;
    rdy_mode = 2'd1;
    xfer(1'b0, 4'd3, 8'h00);
    wait_drain();
    checks++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      errors++; $display("FAIL bp_count got %0d required 3", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_order[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_fill();
    int off;
    rdy_mode = 2'd1;
    for (int a = 0; a < DEPTH; a++) xfer(1'b1, 4'(a), 8'h5A);
    init_start = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL fill_start_ready got %b required 0", req_ready);
    end
    @(posedge clk);
    model_fill(DEPTH);
    #1 init_start = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== (i < DEPTH)) begin
        errors++; $display("FAIL fill_busy[%0d] got %b required %b", i, busy, (i < DEPTH));
      end
      if (i < DEPTH) begin
        checks++;
        if (req_ready !== 1'b0 || {ram_cs, ram_wen, ram_ren} !== 3'b110 || ram_waddr !== 4'(i) || ram_wdata !== INIT) begin
          errors++;
          $display("FAIL fill_write[%0d] ready %b cs/wen/ren %b waddr %0d wdata %h required 0 110 %0d %h",
                   i, req_ready, {ram_cs, ram_wen, ram_ren}, ram_waddr, ram_wdata, i, INIT);
        end
      end
    end
    @(posedge clk); #1;
    off = $urandom_range(0, DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 4'((i * 7 + off) % DEPTH), 8'h00);
    wait_drain();
    checks++;
    if (got_q.size() != DEPTH) begin
      errors++; $display("FAIL fill_count got %0d required %0d", got_q.size(), DEPTH);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i] !== INIT) begin
        errors++; $display("FAIL fill_read[%0d] got %h required %h", i, got_q[i], INIT);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_init_priority();
    int n = 0;
    rdy_mode = 2'd1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_wdata = 8'hFF; init_start = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL prio_ready got %b required 0", req_ready);
    end
    @(posedge clk);
    model_fill(DEPTH);
    #1 init_start = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL prio_wait got %0d cycles required %0d", n, DEPTH);
    end
    commit();
    xfer(1'b0, 4'd0, 8'h00);
    xfer(1'b0, 4'd9, 8'h00);
    wait_drain();
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'hFF || got_q[1] !== INIT) begin
      errors++; $display("FAIL prio_data got %0d responses first %h required 2 ff", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_alternate();
    rdy_mode = 2'd1;
    for (int k = 0; k < 10; k++) begin
      xfer(1'b1, 4'd15, 8'(k));
      xfer(1'b0, 4'd15, 8'h00);
    end
    wait_drain();
    checks++;
    if (got_q.size() != 10) begin
      errors++; $display("FAIL alt_count got %0d required 10", got_q.size());
    end
    for (int k = 0; k < 10 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== 8'(k) || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL alt_data[%0d] got %h required %h", k, got_q[k], 8'(k));
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int n;
    rdy_mode = 2'd2;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 99) < 3) begin
        n = 0;
        while (busy === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        init_start = 1'b1;
        @(posedge clk);
        model_fill(DEPTH);
        #1 init_start = 1'b0;
      end else begin
        xfer(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rdy_mode = 2'd1;
    wait_drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_data[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    rdy_mode = 2'd1;
    for (int a = 0; a < DEPTH; a++) xfer(1'b1, 4'(a), 8'($urandom) | 8'h01);
    init_start = 1'b1;
    @(posedge clk);
    model_fill(7);
    #1 init_start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy, ram_cs, ram_wen, ram_ren} !== 6'b0 || ram_waddr !== 4'd0 || ram_wdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_fill ready/valid/busy/cs/wen/ren %b waddr %0d required 000000 0",
               {req_ready, rsp_valid, busy, ram_cs, ram_wen, ram_ren}, ram_waddr);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_cs !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_fill_after busy %b cs %b ready %b valid %b required 0 0 1 0", busy, ram_cs, req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    for (int a = 0; a < DEPTH; a++) xfer(1'b0, 4'(a), 8'h00);
    wait_drain();
    checks++;
    if (got_q.size() != DEPTH) begin
      errors++; $display("FAIL rst_fill_count got %0d required %0d", got_q.size(), DEPTH);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_fill_data[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
    rdy_mode = 2'd0;
    xfer(1'b0, 4'd2, 8'h00);
    xfer(1'b0, 4'd11, 8'h00);
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || ram_cs !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_read valid %b cs %b ready %b required 0 0 0", rsp_valid, ram_cs, req_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    rdy_mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rst_read_abandon[%0d] rsp_valid %b required 0", i, rsp_valid);
      end
    end
    @(posedge clk); #1;
    xfer(1'b0, 4'd12, 8'h00);
    wait_drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL rst_read_resume got %0d responses required 1 of %h", got_q.size(), exp_q[0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
    test_reset();
    test_write_read();
    test_backpressure();
    test_fill();
    test_init_priority();
    test_alternate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
